// File: rtl/imem_program_loader.sv
// Byte-stream program loader: assembles length-prefixed, XOR-checksummed little-endian
// bytes into 32-bit words, writes them to instruction memory and releases the core on success.
module imem_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [2:0]            dbg_state_o
);

  // Handshake: a byte moves only on a cycle with in_valid && in_ready; in_ready is
  // high in every loading state and low in DONE/ERROR, so a load never stalls.
  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  state_t                state_q;
  logic [15:0]           len_q;
  logic [7:0]            chk_q;
  logic [1:0]            byte_cnt_q;
  logic [ADDR_WIDTH:0]   word_idx_q;
  logic [23:0]           word_buf_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic                  cpu_reset_q;
  logic                  load_done_q;
  logic                  load_error_q;

  logic                  accept;
  logic [15:0]           len_d;
  logic                  last_word;

  always_comb begin
    in_ready  = (state_q != S_DONE) && (state_q != S_ERROR);
    accept    = in_valid && in_ready;
    len_d     = {in_data, len_q[7:0]};
    // Index is one bit wider than the address so a full-capacity load never wraps.
    last_word = ((17'(word_idx_q) + 17'd1) == {1'b0, len_q});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LEN_LO;
      len_q        <= '0;
      chk_q        <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      word_buf_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= in_data;
            state_q    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_q      <= len_d;
            chk_q      <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            if ({1'b0, len_d} > CAP) begin
              state_q      <= S_ERROR;
              load_error_q <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            chk_q      <= chk_q ^ in_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: word_buf_q[7:0]   <= in_data;
              2'd1: word_buf_q[15:8]  <= in_data;
              2'd2: word_buf_q[23:16] <= in_data;
              default: begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= word_idx_q[ADDR_WIDTH-1:0];
                imem_wdata_q <= {in_data, word_buf_q};
                word_idx_q   <= word_idx_q + 1'b1;
                if (last_word) state_q <= S_CHK;
              end
            endcase
          end
        end
        S_CHK: begin
          if (accept) begin
            if (in_data == chk_q) begin
              state_q     <= S_DONE;
              cpu_reset_q <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              state_q      <= S_ERROR;
              load_error_q <= 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            state_q      <= S_LEN_LO;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
          end
        end
        default: state_q <= S_LEN_LO;
      endcase
    end
  end

  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: byte streams in, imem writes and status checked
// against hand-computed words held in an expected-write queue.
module tb_imem_program_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  stream_q[$];

  imem_program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e[39:32]));
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; start = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0; in_data = 8'hxx;
    repeat (gap) tick();
  endtask

  task automatic send_stream(input int gap);
    foreach (stream_q[i]) send_byte(stream_q[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_cpu_reset", 32'(cpu_reset), 1);
    check("start_in_ready", 32'(in_ready), 1);
    check("start_done", 32'(load_done), 0);
    check("start_error", 32'(load_error), 0);
  endtask

  task automatic expect_two_words();
    exp_q.push_back({8'd0, 32'h0050_0093});
    exp_q.push_back({8'd1, 32'h00A0_0113});
  endtask

  task automatic check_done(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 0);
    check({tag, "_done"}, 32'(load_done), 1);
    check({tag, "_error"}, 32'(load_error), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_pending"}, 32'(exp_q.size()), 0);
  endtask

  int w0;

  initial begin
    in_data = 8'h00;
    do_reset();
    check("rst_state", 32'(dbg_state), 0);
    check("rst_cpu_reset", 32'(cpu_reset), 1);
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_error", 32'(load_error), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    // two-word load, start pulsed mid-load must be ignored
    expect_two_words();
    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    send_stream(0);
    start = 1'b1;
    send_byte(8'h13, 0);
    start = 1'b0;
    check("ign_start_state", 32'(dbg_state), 2);
    stream_q = '{8'h01, 8'hA0, 8'h00, 8'h71};
    send_stream(0);
    check_done("two_word");
    tick();
    check("done_sticky", 32'(load_done), 1);
    pulse_start();

    // bad checksum, then re-arm and resend
    expect_two_words();
    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h70};
    send_stream(0);
    check("badchk_error", 32'(load_error), 1);
    check("badchk_cpu_reset", 32'(cpu_reset), 1);
    check("badchk_in_ready", 32'(in_ready), 0);
    check("badchk_done", 32'(load_done), 0);
    check("badchk_pending", 32'(exp_q.size()), 0);
    pulse_start();
    expect_two_words();
    stream_q[10] = 8'h71;
    send_stream(0);
    check_done("resend");
    pulse_start();

    // empty program
    w0 = wr_cnt;
    stream_q = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    check_done("empty");
    check("empty_no_we", 32'(wr_cnt - w0), 0);
    pulse_start();

    // overflow N=257: error right after length, trailing bytes ignored
    w0 = wr_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("ovf_error", 32'(load_error), 1);
    check("ovf_cpu_reset", 32'(cpu_reset), 1);
    check("ovf_in_ready", 32'(in_ready), 0);
    stream_q = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h00};
    send_stream(0);
    check("ovf_state", 32'(dbg_state), 5);
    check("ovf_no_we", 32'(wr_cnt - w0), 0);
    pulse_start();

    // throttled stream, 3 idle cycles after every byte
    expect_two_words();
    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    send_stream(3);
    check_done("throttle");
    pulse_start();

    // reset after 6 data bytes: only word 0 written
    w0 = wr_cnt;
    exp_q.push_back({8'd0, 32'h0050_0093});
    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
    send_stream(0);
    do_reset();
    tick();
    check("midrst_writes", 32'(wr_cnt - w0), 1);
    check("midrst_state", 32'(dbg_state), 0);
    check("midrst_cpu_reset", 32'(cpu_reset), 1);
    check("midrst_we", 32'(imem_we), 0);
    expect_two_words();
    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    send_stream(0);
    check_done("after_rst");
    pulse_start();

    // full capacity N=256: word i = {A5,00,00,i}; checksum XOR over all bytes is 00
    w0 = wr_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({8'(i), 8'hA5, 16'h0000, 8'(i)});
      send_byte(8'(i), 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'hA5, 0);
    end
    send_byte(8'h00, 0);
    check_done("full");
    check("full_writes", 32'(wr_cnt - w0), 256);
    check("full_last_addr", 32'(imem_addr), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time limit so a stuck design still reaches the summary
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Byte-stream program loader for the single-cycle RISC-V core's instruction memory.
- Receives a length-prefixed, checksummed stream of little-endian instruction bytes over a valid/ready interface.
- Assembles the bytes into 32-bit words and writes them sequentially into instruction memory starting at word 0.
- Holds the core in reset until a load completes with a good checksum. It is the producer side of the instruction words that the core fetches and the trace monitor decodes.

Parameters:
- ADDR_WIDTH, 8, width of the instruction-memory word address; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  re-arm pulse; honoured only in DONE or ERROR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  reset to the core; 1 while loading.
- load_done  out  1  sticky; load finished with good checksum.
- load_error  out  1  sticky; checksum mismatch or length overflow.

Behaviour:
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes (byte 0 = instr[7:0]), then one checksum byte = XOR of all data bytes only (length bytes excluded).
- Byte transfer: a byte is accepted only on a cycle where in_valid=1 and in_ready=1. in_data is ignored otherwise.
- in_ready: combinational; equals 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CHK; equals 0 in S_DONE and S_ERROR. The loader never stalls inside a load.
- FSM states: S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERROR.
  - S_LEN_LO -> S_LEN_HI on accept; captures len[7:0].
  - S_LEN_HI on accept, captures len[15:8], clears checksum accumulator, byte counter and word index, then:
    - N > 2^ADDR_WIDTH -> S_ERROR;
    - N == 0 -> S_CHK;
    - otherwise -> S_DATA.
  - S_DATA: each accept XORs the byte into the checksum, shifts it into the word at lane byte_cnt, and increments byte_cnt (2 bits, wraps).
    - On the 4th byte, the next cycle drives imem_we=1, imem_addr = word index, imem_wdata = the full word; word index then increments.
    - After word N-1's 4th byte -> S_CHK.
  - S_CHK on accept: byte == accumulator -> S_DONE, otherwise -> S_ERROR.
  - S_DONE / S_ERROR: start=1 -> S_LEN_LO, clearing load_done and load_error.
- Output timing (all outputs registered):
  - Write latency: imem_we is asserted exactly 1 cycle after the 4th byte of a word is accepted, for exactly 1 cycle.
  - cpu_reset falls and load_done rises 1 cycle after an accepted checksum byte matches.
  - On mismatch or overflow, load_error rises 1 cycle after the deciding byte and cpu_reset stays 1.
  - cpu_reset returns to 1 the cycle after an honoured start.
- Reset values: state S_LEN_LO, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_error=0; internal counters and accumulator 0.
- Boundary conditions:
  - start outside DONE/ERROR is ignored.
  - Reset mid-load discards the partial word; no write is issued for it.
  - Gaps in in_valid (any length) do not change state or counters.
  - N == 2^ADDR_WIDTH is legal; the final write is at address 2^ADDR_WIDTH-1.
  - The word index must not wrap during a legal load.
  - Memory contents from previous loads are not cleared.

Test Plan:
- Two-word load, ADDR_WIDTH=8: bytes 02 00 93 00 50 00 13 01 A0 00 71 with in_valid held 1 -> imem writes addr0=0x00500093, addr1=0x00A00113, each as a single-cycle imem_we. One cycle after byte 0x71, cpu_reset=0 and load_done=1.
- Same stream with checksum 0x70 -> both words are written, then load_error=1, cpu_reset stays 1, in_ready=0. Then start=1 -> in_ready=1, load_error=0, and a correct resend completes.
- Empty program: bytes 00 00 00 -> no imem_we; load_done=1; cpu_reset=0.
- Overflow: bytes 01 01 (N=257) -> load_error=1 one cycle after the second byte; no imem_we; further bytes are ignored.
- Throttled stream: the two-word load with in_valid low on random cycles (e.g., 3 idle cycles after every byte) -> identical writes and result to the first scenario.
- Reset mid-load: assert reset after 6 data bytes -> only addr0 has been written, state returns to S_LEN_LO, cpu_reset=1, and a subsequent full two-word stream completes normally.
